// File: rtl/video_pkg.sv
// Shared video constants: fvht bit positions, blanking codes and the colour-bar table.
// Consumers of the timing/video stream import this to decode fvht and recognise blanking.
package video_pkg;

  localparam int FVHT_T = 0;
  localparam int FVHT_H = 1;
  localparam int FVHT_V = 2;
  localparam int FVHT_F = 3;

  localparam logic [3:0] FVHT_RESET = 4'b0110;

  localparam logic [9:0] BLANK_Y = 10'h040;
  localparam logic [9:0] BLANK_C = 10'h200;

  typedef enum logic {
    PAT_BARS = 1'b0,
    PAT_FLAT = 1'b1
  } pat_e;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] cb;
    logic [9:0] cr;
  } ycbcr_t;

  localparam int NUM_BARS = 8;

  // 75% bars, 10-bit: white, yellow, cyan, green, magenta, red, blue, black
  localparam ycbcr_t BAR_TABLE [NUM_BARS] = '{
    '{y: 10'h2D0, cb: 10'h200, cr: 10'h200},
    '{y: 10'h2A2, cb: 10'h0B0, cr: 10'h21F},
    '{y: 10'h245, cb: 10'h24D, cr: 10'h0B0},
    '{y: 10'h216, cb: 10'h0FD, cr: 10'h0CF},
    '{y: 10'h0FB, cb: 10'h303, cr: 10'h331},
    '{y: 10'h0CC, cb: 10'h1B3, cr: 10'h350},
    '{y: 10'h06F, cb: 10'h350, cr: 10'h1E1},
    '{y: 10'h040, cb: 10'h200, cr: 10'h200}
  };

  // 4:2:2 multiplex: even samples carry Cb, odd samples carry Cr
  function automatic logic [19:0] sample_422(input ycbcr_t c, input logic odd);
    return {c.y, (odd ? c.cr : c.cb)};
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Raster counters and registered F/V/H/T decode, plus the completed-frame counter.
// Exposes the current counter state so the pixel datapath can stay aligned with fvht.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1125,
  localparam int HC_W = $clog2(H_TOTAL),
  localparam int VC_W = $clog2(V_TOTAL)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cen_i,
  output logic [HC_W-1:0] hc_o,
  output logic            sof_o,
  output logic            blank_o,
  output logic [3:0]      fvht_o,
  output logic [15:0]     frame_cnt_o
);

  localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_LAST_C = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_LAST_C = VC_W'(V_TOTAL - 1);

  logic [HC_W-1:0] r_hc;
  logic [VC_W-1:0] r_vc;
  logic [3:0]      r_fvht_p1;
  logic [15:0]     r_frame_cnt;

  logic w_h_end;
  logic w_v_end;
  logic w_sof;
  logic w_h_blank;
  logic w_v_blank;

  assign w_h_end   = (r_hc == H_LAST_C);
  assign w_v_end   = (r_vc == V_LAST_C);
  assign w_sof     = (r_hc == '0) && (r_vc == '0);
  assign w_h_blank = (r_hc >= H_ACT_C);
  assign w_v_blank = (r_vc >= V_ACT_C);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hc        <= '0;
      r_vc        <= '0;
      r_fvht_p1   <= FVHT_RESET;
      r_frame_cnt <= '0;
    end else if (cen_i) begin
      r_hc <= w_h_end ? '0 : r_hc + HC_W'(1);
      if (w_h_end) begin
        r_vc <= w_v_end ? '0 : r_vc + VC_W'(1);
      end
      if (w_h_end && w_v_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      // stage p0 -> p1: decode of the sample held this cycle; F is its own state bit
      r_fvht_p1[FVHT_F] <= r_fvht_p1[FVHT_F] ^ w_sof;
      r_fvht_p1[FVHT_V] <= w_v_blank;
      r_fvht_p1[FVHT_H] <= w_h_blank;
      r_fvht_p1[FVHT_T] <= w_sof;
    end
  end

  assign hc_o        = r_hc;
  assign sof_o       = w_sof;
  assign blank_o     = w_h_blank | w_v_blank;
  assign fvht_o      = r_fvht_p1;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: rtl/video_timing_gen.sv
// Test-pattern video source: raster timing from video_timing_cnt plus a colour-bar /
// flat-colour 4:2:2 datapath whose pattern settings are sampled once per frame.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1125
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic        pat_sel_i,
  input  logic [29:0] colour_i,
  output logic [3:0]  fvht_o,
  output logic [19:0] video_o,
  output logic [15:0] frame_cnt_o
);

  localparam int HC_W  = $clog2(H_TOTAL);
  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  logic [HC_W-1:0] w_hc;
  logic            w_sof;
  logic            w_blank;

  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cen_i       (cen_i),
    .hc_o        (w_hc),
    .sof_o       (w_sof),
    .blank_o     (w_blank),
    .fvht_o      (fvht_o),
    .frame_cnt_o (frame_cnt_o)
  );

  // Threshold count instead of a divider; anything past bar 7 stays black.
  function automatic logic [2:0] bar_index(input logic [HC_W-1:0] hc);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (int'(hc) >= k * BAR_W) idx = 3'(k);
    end
    return idx;
  endfunction

  pat_e   r_pat;
  ycbcr_t r_colour;
  logic [19:0] r_video_p1;

  pat_e   w_pat;
  ycbcr_t w_colour;
  ycbcr_t w_pix;
  logic [19:0] w_video;

  // The frame-start sample takes the inputs directly so a whole frame shares one setting.
  assign w_pat    = w_sof ? pat_e'(pat_sel_i) : r_pat;
  assign w_colour = w_sof ? ycbcr_t'(colour_i) : r_colour;

  always_comb begin
    w_pix   = BAR_TABLE[bar_index(w_hc)];
    w_video = {BLANK_Y, BLANK_C};
    if (w_pat == PAT_FLAT) w_pix = w_colour;
    if (!w_blank) w_video = sample_422(w_pix, w_hc[0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pat      <= PAT_BARS;
      r_colour   <= '0;
      r_video_p1 <= {BLANK_Y, BLANK_C};
    end else if (cen_i) begin
      // stage p0 -> p1: pixel for the sample held this cycle
      r_video_p1 <= w_video;
      if (w_sof) begin
        r_pat    <= w_pat;
        r_colour <= w_colour;
      end
    end
  end

  assign video_o = r_video_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster: a reference model queues the expected
// outputs per clock edge, a monitor pops and compares, and directed checks pin key samples.
module tb_video_timing_gen;

  localparam int HA = 20;
  localparam int HT = 24;
  localparam int VA = 5;
  localparam int VT = 8;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        pat_sel;
  logic [29:0] colour;
  logic [3:0]  fvht;
  logic [19:0] video;
  logic [15:0] frame_cnt;

  video_timing_gen #(
    .H_ACTIVE (HA),
    .H_TOTAL  (HT),
    .V_ACTIVE (VA),
    .V_TOTAL  (VT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cen_i       (cen),
    .pat_sel_i   (pat_sel),
    .colour_i    (colour),
    .fvht_o      (fvht),
    .video_o     (video),
    .frame_cnt_o (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  fvht;
    logic [19:0] video;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  int          m_hc, m_vc;
  bit          m_f, m_pat;
  logic [29:0] m_col;
  logic [15:0] m_fc;
  exp_t        m_exp;

  logic [29:0] bars [8] = '{
    {10'h2D0, 10'h200, 10'h200}, {10'h2A2, 10'h0B0, 10'h21F},
    {10'h245, 10'h24D, 10'h0B0}, {10'h216, 10'h0FD, 10'h0CF},
    {10'h0FB, 10'h303, 10'h331}, {10'h0CC, 10'h1B3, 10'h350},
    {10'h06F, 10'h350, 10'h1E1}, {10'h040, 10'h200, 10'h200}
  };

  logic [39:0] rec [FRAME+1];

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit ps, input logic [29:0] col);
    bit sof, h, v;
    int idx;
    logic [29:0] px;
    logic [9:0]  ch;
    if (r) begin
      m_hc = 0; m_vc = 0; m_f = 0; m_pat = 0; m_col = '0; m_fc = '0;
      m_exp = '{fvht: 4'b0110, video: {10'h040, 10'h200}, fc: 16'h0};
    end else if (c) begin
      sof = (m_hc == 0) && (m_vc == 0);
      if (sof) begin
        m_pat = ps; m_col = col; m_f = ~m_f;
      end
      h = (m_hc >= HA);
      v = (m_vc >= VA);
      idx = m_hc / (HA / 8);
      if (idx > 7) idx = 7;
      px = m_pat ? m_col : bars[idx];
      ch = m_hc[0] ? px[9:0] : px[19:10];
      m_exp.video = (h || v) ? {10'h040, 10'h200} : {px[29:20], ch};
      m_exp.fvht  = {m_f, v, h, sof};
      if (m_hc == HT - 1) begin
        m_hc = 0;
        if (m_vc == VT - 1) begin
          m_vc = 0;
          m_fc = m_fc + 16'd1;
        end else begin
          m_vc++;
        end
      end else begin
        m_hc++;
      end
      m_exp.fc = m_fc;
    end
    q.push_back(m_exp);
  endtask

  // One clock: drive inputs, queue the expected result, return at the following negedge.
  task automatic cyc(input bit r, input bit c);
    rst = r;
    cen = c;
    model_step(r, c, pat_sel, colour);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({fvht, video, frame_cnt} !== e) begin
          errors++;
          $display("FAIL scoreboard @%0t: got fvht=%b video=%h fc=%0d, expected fvht=%b video=%h fc=%0d",
                   $time, fvht, video, frame_cnt, e.fvht, e.video, e.fc);
        end
      end
    end
  end

  initial begin
    int h0, h1, tcount, tfirst, tsecond, e_idx, mism, holdbad;
    logic [39:0] prev;
    rst = 1'b1; cen = 1'b0; pat_sel = 1'b0; colour = '0;

    // Reset, including a cycle where cen is also high
    cyc(1, 1);
    cyc(1, 0);
    check("reset_fvht", 40'(fvht), 40'(4'b0110));
    check("reset_video", 40'(video), 40'({10'h040, 10'h200}));
    check("reset_fc", 40'(frame_cnt), 40'd0);

    // Continuous enable, colour bars
    h0 = 0; h1 = 0; tcount = 0; tfirst = -1; tsecond = -1;
    for (int n = 0; n <= FRAME; n++) begin
      cyc(0, 1);
      rec[n] = {fvht, video, frame_cnt};
      if (n < HT) begin
        if (fvht[1]) h1++; else h0++;
      end
      if (fvht[0]) begin
        tcount++;
        if (tfirst < 0) tfirst = n; else if (tsecond < 0) tsecond = n;
      end
      case (n)
        0: begin
          check("first_fvht", 40'(fvht), 40'(4'b1001));
          check("first_video_white", 40'(video), 40'({10'h2D0, 10'h200}));
        end
        2:   check("yellow_cb", 40'(video), 40'({10'h2A2, 10'h0B0}));
        13:  check("blue_cr", 40'(video), 40'({10'h06F, 10'h1E1}));
        14:  check("black_after_blue", 40'(video), 40'({10'h040, 10'h200}));
        17:  check("clamped_black", 40'(video), 40'({10'h040, 10'h200}));
        21: begin
          check("hblank_fvht", 40'(fvht), 40'(4'b1010));
          check("hblank_video", 40'(video), 40'({10'h040, 10'h200}));
        end
        HT:        check("line1_start_fvht", 40'(fvht), 40'(4'b1000));
        VA * HT:   check("vblank_fvht", 40'(fvht), 40'(4'b1100));
        FRAME - 2: check("fc_before_wrap", 40'(frame_cnt), 40'd0);
        FRAME - 1: check("fc_after_wrap", 40'(frame_cnt), 40'd1);
        FRAME: begin
          check("frame2_fvht", 40'(fvht), 40'(4'b0001));
          check("frame2_video", 40'(video), 40'({10'h2D0, 10'h200}));
        end
        default: ;
      endcase
    end
    check("line_active_count", 40'(h0), 40'(HA));
    check("line_blank_count", 40'(h1), 40'(HT - HA));
    check("t_count", 40'(tcount), 40'd2);
    check("t_period", 40'(tsecond - tfirst), 40'(FRAME));

    // Enable toggled every cycle: same enabled-output sequence, held otherwise
    cyc(1, 0);
    prev = {fvht, video, frame_cnt};
    e_idx = 0; mism = 0; holdbad = 0;
    for (int k = 0; k < 2 * (FRAME + 1); k++) begin
      cyc(0, (k % 2) == 0);
      if ((k % 2) == 0) begin
        if ({fvht, video, frame_cnt} !== rec[e_idx]) mism++;
        e_idx++;
      end else if ({fvht, video, frame_cnt} !== prev) begin
        holdbad++;
      end
      prev = {fvht, video, frame_cnt};
    end
    check("cen_toggle_sequence", 40'(mism), 40'd0);
    check("cen_toggle_hold", 40'(holdbad), 40'd0);

    // Flat colour requested mid-frame takes effect at the next frame only
    cyc(1, 0);
    for (int n = 0; n <= FRAME + HT + 2; n++) begin
      if (n == 2 * HT + 5) begin
        pat_sel = 1'b1;
        colour  = {10'h100, 10'h180, 10'h280};
      end
      if (n == FRAME + 8) pat_sel = 1'b0;
      cyc(0, 1);
      case (n)
        3 * HT + 13:    check("bars_after_change", 40'(video), 40'({10'h06F, 10'h1E1}));
        FRAME:          check("flat_even_cb", 40'(video), 40'({10'h100, 10'h180}));
        FRAME + 1:      check("flat_odd_cr", 40'(video), 40'({10'h100, 10'h280}));
        FRAME + HT + 2: check("flat_held_in_frame", 40'(video), 40'({10'h100, 10'h180}));
        default: ;
      endcase
    end

    // Reset mid-frame after one completed frame aborts the frame and clears the count
    cyc(1, 0);
    for (int n = 0; n < FRAME + 3 * HT + 10; n++) cyc(0, 1);
    check("fc_before_abort", 40'(frame_cnt), 40'd1);
    cyc(1, 1);
    check("abort_fc", 40'(frame_cnt), 40'd0);
    check("abort_fvht", 40'(fvht), 40'(4'b0110));
    cyc(0, 1);
    check("restart_fvht", 40'(fvht), 40'(4'b1001));
    check("restart_video", 40'(video), 40'({10'h2D0, 10'h200}));
    for (int n = 1; n < 2 * FRAME; n++) cyc(0, 1);
    check("fc_two_frames", 40'(frame_cnt), 40'd2);

    cyc(0, 0);
    cyc(0, 0);
    check("queue_drained", 40'(q.size()), 40'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
